// File: rtl/leaf_pkt_pkg.sv
// Shared widths, packet layout and credit arithmetic for the leaf output packetizer.
package leaf_pkt_pkg;

  localparam int unsigned PAYLOAD_BITS  = 32;
  localparam int unsigned NUM_LEAF_BITS = 5;
  localparam int unsigned NUM_PORT_BITS = 4;
  localparam int unsigned NUM_ADDR_BITS = 7;
  localparam int unsigned PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
  localparam int unsigned DST_BITS      = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int unsigned SEL_BITS      = 3;
  localparam int unsigned CREDIT_BITS   = 8;
  localparam int unsigned CREDIT_INIT   = 128;
  localparam int unsigned STAT_BITS     = 16;

  localparam int unsigned PKT_ADDR_LSB  = PAYLOAD_BITS;
  localparam int unsigned PKT_PORT_LSB  = PKT_ADDR_LSB + NUM_ADDR_BITS;
  localparam int unsigned PKT_LEAF_LSB  = PKT_PORT_LSB + NUM_PORT_BITS;
  localparam int unsigned PKT_VLD_BIT   = PKT_LEAF_LSB + NUM_LEAF_BITS;

  typedef logic [NUM_ADDR_BITS-1:0] addr_t;
  typedef logic [CREDIT_BITS-1:0]   credit_t;

  typedef struct packed {
    logic                     vld;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    addr_t                    addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } leaf_pkt_t;

  // Spend one credit on a grant, add any returned credits, clamp at the remote buffer depth.
  function automatic credit_t credit_next(input credit_t cur, input logic take,
                                          input logic give, input credit_t amt);
    logic [CREDIT_BITS:0] sum;
    sum = {1'b0, cur} - (CREDIT_BITS+1)'(take) + (give ? {1'b0, amt} : '0);
    if (sum > (CREDIT_BITS+1)'(CREDIT_INIT)) return CREDIT_BITS'(CREDIT_INIT);
    return sum[CREDIT_BITS-1:0];
  endfunction

endpackage

// File: rtl/leaf_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search begins at the port after the last grant.
module leaf_rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] ptr_q;
  logic [IW:0]   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (en && !grant_any && req[idx[IW-1:0]]) begin
        grant[idx[IW-1:0]] = 1'b1;
        grant_idx          = idx[IW-1:0];
        grant_any          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant_any) begin
      ptr_q <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/leaf_out_packetizer.sv
// Tags user output words with destination/address and emits credit-limited BFT packets.
// Optional per-port sent counters are built when LEAF_PKT_STATS_EN is defined.
module leaf_out_packetizer
  import leaf_pkt_pkg::*;
#(
  parameter int unsigned NUM_OUT_PORTS = 2
) (
  input  logic                                 clk_user,
  input  logic                                 reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user2pkt,
  input  logic [NUM_OUT_PORTS-1:0]             vld_user2pkt,
  output logic [NUM_OUT_PORTS-1:0]             ack_pkt2user,
  output logic [PACKET_BITS-1:0]               dout_pkt,
  output logic                                 dout_vld,
  input  logic                                 dout_rdy,
  input  logic                                 cfg_we,
  input  logic [SEL_BITS-1:0]                  cfg_port,
  input  logic [DST_BITS-1:0]                  cfg_dst,
  input  logic                                 credit_vld,
  input  logic [SEL_BITS-1:0]                  credit_port,
  input  logic [CREDIT_BITS-1:0]               credit_cnt,
  output logic [NUM_OUT_PORTS*STAT_BITS-1:0]   stat_sent
);

  localparam int unsigned IDX_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  logic [NUM_OUT_PORTS-1:0] tbl_vld;
  logic [DST_BITS-1:0]      tbl_dst  [NUM_OUT_PORTS];
  addr_t                    addr_q   [NUM_OUT_PORTS];
  credit_t                  credit_q [NUM_OUT_PORTS];
  credit_t                  credit_d [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0]  din_arr  [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] req;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_any;
  logic                     loadable;
  leaf_pkt_t                pkt_q;

  assign dout_pkt     = pkt_q;
  assign dout_vld     = pkt_q.vld;
  assign loadable     = !pkt_q.vld || dout_rdy;
  assign ack_pkt2user = grant;

  // Eligibility, payload unpacking and next credit per port.
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      req[i]      = vld_user2pkt[i] && tbl_vld[i] && (credit_q[i] != '0);
      din_arr[i]  = din_user2pkt[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      credit_d[i] = credit_next(credit_q[i], grant[i],
                                credit_vld && (credit_port == SEL_BITS'(i)), credit_cnt);
    end
  end

  leaf_rr_arbiter #(.N(NUM_OUT_PORTS)) u_arb (
    .clk       (clk_user),
    .reset     (reset),
    .en        (loadable),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_ff @(posedge clk_user) begin
    if (reset) begin
      pkt_q   <= '0;
      tbl_vld <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        tbl_dst[i]  <= '0;
        addr_q[i]   <= '0;
        credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
      end
    end else begin
      if (grant_any) begin
        pkt_q.vld     <= 1'b1;
        pkt_q.leaf    <= tbl_dst[grant_idx][DST_BITS-1 -: NUM_LEAF_BITS];
        pkt_q.port    <= tbl_dst[grant_idx][NUM_PORT_BITS-1:0];
        pkt_q.addr    <= addr_q[grant_idx];
        pkt_q.payload <= din_arr[grant_idx];
      end else if (dout_rdy) begin
        pkt_q.vld <= 1'b0;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        if (grant[i]) addr_q[i] <= addr_q[i] + addr_t'(1);
        // New destination only affects words granted from the next cycle on.
        if (cfg_we && (cfg_port == SEL_BITS'(i))) begin
          tbl_vld[i] <= 1'b1;
          tbl_dst[i] <= cfg_dst;
        end
      end
    end
  end

`ifdef LEAF_PKT_STATS_EN
  logic [STAT_BITS-1:0] stat_q [NUM_OUT_PORTS];

  always_ff @(posedge clk_user) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (grant[i]) stat_q[i] <= stat_q[i] + STAT_BITS'(1);
      end
    end
  end

  always_comb begin
    stat_sent = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) stat_sent[i*STAT_BITS +: STAT_BITS] = stat_q[i];
  end
`else
  assign stat_sent = '0;
`endif

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Directed self-checking bench for leaf_out_packetizer (two output ports).
module tb_leaf_out_packetizer;

  logic        clk_user = 1'b0;
  logic        reset;
  logic [63:0] din_user2pkt;
  logic [1:0]  vld_user2pkt;
  logic [1:0]  ack_pkt2user;
  logic [48:0] dout_pkt;
  logic        dout_vld;
  logic        dout_rdy;
  logic        cfg_we;
  logic [2:0]  cfg_port;
  logic [8:0]  cfg_dst;
  logic        credit_vld;
  logic [2:0]  credit_port;
  logic [7:0]  credit_cnt;
  logic [31:0] stat_sent;

  int n_assert = 0;
  int n_fail   = 0;
  int n_ack;
  logic [48:0] exp_pkt;

  always #5 clk_user = ~clk_user;

  leaf_out_packetizer #(.NUM_OUT_PORTS(2)) dut (
    .clk_user     (clk_user),
    .reset        (reset),
    .din_user2pkt (din_user2pkt),
    .vld_user2pkt (vld_user2pkt),
    .ack_pkt2user (ack_pkt2user),
    .dout_pkt     (dout_pkt),
    .dout_vld     (dout_vld),
    .dout_rdy     (dout_rdy),
    .cfg_we       (cfg_we),
    .cfg_port     (cfg_port),
    .cfg_dst      (cfg_dst),
    .credit_vld   (credit_vld),
    .credit_port  (credit_port),
    .credit_cnt   (credit_cnt),
    .stat_sent    (stat_sent)
  );

  task automatic tick();
    @(posedge clk_user);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [2:0] p, input logic [4:0] leaf, input logic [3:0] port);
    cfg_we = 1'b1; cfg_port = p; cfg_dst = {leaf, port};
    tick();
    cfg_we = 1'b0;
  endtask

  function automatic logic [48:0] mk(input logic [4:0] l, input logic [3:0] p,
                                     input logic [6:0] a, input logic [31:0] d);
    return {1'b1, l, p, a, d};
  endfunction

  initial begin
    reset = 1'b1; din_user2pkt = '0; vld_user2pkt = '0; dout_rdy = 1'b1;
    cfg_we = 1'b0; cfg_port = '0; cfg_dst = '0;
    credit_vld = 1'b0; credit_port = '0; credit_cnt = '0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("reset_vld", 64'(dout_vld), 64'd0);
    chk("reset_pkt", 64'(dout_pkt), 64'd0);
    chk("reset_ack", 64'(ack_pkt2user), 64'd0);
    chk("reset_stat", 64'(stat_sent), 64'd0);

    // Single word, port0 -> leaf 3 port 2
    cfg(3'd0, 5'd3, 4'd2);
    din_user2pkt[31:0] = 32'hDEADBEEF; vld_user2pkt = 2'b01;
    #1 chk("single_ack", 64'(ack_pkt2user), 64'b01);
    tick();
    vld_user2pkt = 2'b00;
    chk("single_vld", 64'(dout_vld), 64'd1);
    chk("single_pkt", 64'(dout_pkt), 64'(mk(5'd3, 4'd2, 7'd0, 32'hDEADBEEF)));
    tick();
    chk("single_drain", 64'(dout_vld), 64'd0);

    // Round-robin alternation from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    cfg(3'd0, 5'd3, 4'd2);
    cfg(3'd1, 5'd7, 4'd5);
    for (int k = 0; k < 4; k++) begin
      din_user2pkt = {32'hB000_0000 | 32'(k), 32'hA000_0000 | 32'(k)};
      vld_user2pkt = 2'b11;
      #1 chk("rr_ack", 64'(ack_pkt2user), (k % 2 == 0) ? 64'b01 : 64'b10);
      tick();
      exp_pkt = (k % 2 == 0) ? mk(5'd3, 4'd2, 7'(k / 2), 32'hA000_0000 | 32'(k))
                             : mk(5'd7, 4'd5, 7'(k / 2), 32'hB000_0000 | 32'(k));
      chk("rr_pkt", 64'(dout_pkt), 64'(exp_pkt));
    end

    // Backpressure: held packet stays put, nothing acked
    dout_rdy = 1'b0;
    din_user2pkt = {32'hB000_0004, 32'hA000_0004};
    #1 chk("stall_ack0", 64'(ack_pkt2user), 64'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_vld", 64'(dout_vld), 64'd1);
      chk("stall_pkt", 64'(dout_pkt), 64'(exp_pkt));
      chk("stall_ack", 64'(ack_pkt2user), 64'd0);
    end
    dout_rdy = 1'b1;
    #1 chk("resume_ack0", 64'(ack_pkt2user), 64'b01);
    tick();
    chk("resume_pkt0", 64'(dout_pkt), 64'(mk(5'd3, 4'd2, 7'd2, 32'hA000_0004)));
    din_user2pkt = {32'hB000_0005, 32'hA000_0005};
    #1 chk("resume_ack1", 64'(ack_pkt2user), 64'b10);
    tick();
    chk("resume_pkt1", 64'(dout_pkt), 64'(mk(5'd7, 4'd5, 7'd2, 32'hB000_0005)));

    // Reset while a packet is held drops it
    vld_user2pkt = 2'b00; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_vld", 64'(dout_vld), 64'd0);
    chk("midrst_pkt", 64'(dout_pkt), 64'd0);

    // Credit exhaustion, return, address wrap
    cfg(3'd0, 5'd3, 4'd2);
    vld_user2pkt = 2'b01;
    for (int k = 0; k < 128; k++) begin
      din_user2pkt[31:0] = 32'(k);
      #1 chk("credit_ack", 64'(ack_pkt2user), 64'b01);
      tick();
      chk("credit_pkt", 64'(dout_pkt), 64'(mk(5'd3, 4'd2, 7'(k), 32'(k))));
    end
    #1 chk("nocredit_ack", 64'(ack_pkt2user), 64'd0);
    tick();
    chk("nocredit_drain", 64'(dout_vld), 64'd0);
    credit_vld = 1'b1; credit_port = 3'd0; credit_cnt = 8'd4;
    #1 chk("ret_cycle_ack", 64'(ack_pkt2user), 64'd0);
    tick();
    credit_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din_user2pkt[31:0] = 32'(1000 + k);
      #1 chk("ret_ack", 64'(ack_pkt2user), 64'b01);
      tick();
      chk("wrap_pkt", 64'(dout_pkt), 64'(mk(5'd3, 4'd2, 7'(k), 32'(1000 + k))));
    end
    #1 chk("ret_spent_ack", 64'(ack_pkt2user), 64'd0);

    // Out-of-range credit port ignored
    credit_vld = 1'b1; credit_port = 3'd5; credit_cnt = 8'd4;
    tick();
    credit_vld = 1'b0;
    #1 chk("oor_credit_ack", 64'(ack_pkt2user), 64'd0);

    // Saturation at CREDIT_INIT: 100 + 100 returns clamp to 128
    vld_user2pkt = 2'b00;
    credit_vld = 1'b1; credit_port = 3'd0; credit_cnt = 8'd100;
    repeat (2) tick();
    credit_vld = 1'b0;
    vld_user2pkt = 2'b01;
    n_ack = 0;
    for (int c = 0; c < 140; c++) begin
      #1 if (ack_pkt2user == 2'b01) n_ack++;
      tick();
    end
    chk("sat_count", 64'(n_ack), 64'd128);

    // Unconfigured port1 never acked until configured
    vld_user2pkt = 2'b00;
    credit_vld = 1'b1; credit_port = 3'd0; credit_cnt = 8'd10;
    tick();
    credit_vld = 1'b0;
    din_user2pkt = {32'hCAFE_0001, 32'h1234_0000};
    vld_user2pkt = 2'b11;
    for (int c = 0; c < 4; c++) begin
      #1 chk("uncfg_ack", 64'(ack_pkt2user), 64'b01);
      tick();
    end
    cfg_we = 1'b1; cfg_port = 3'd1; cfg_dst = {5'd7, 4'd5};
    #1 chk("cfg_cycle_ack", 64'(ack_pkt2user), 64'b01);
    tick();
    cfg_we = 1'b0;
    #1 chk("cfg_next_ack", 64'(ack_pkt2user), 64'b10);
    tick();
    chk("cfg_pkt", 64'(dout_pkt), 64'(mk(5'd7, 4'd5, 7'd0, 32'hCAFE_0001)));
    vld_user2pkt = 2'b00;

    // Sustained traffic with same-cycle grant + return; sent counters
    reset = 1'b1; tick(); reset = 1'b0;
    cfg(3'd0, 5'd3, 4'd2);
    vld_user2pkt = 2'b01;
    credit_vld = 1'b1; credit_port = 3'd0; credit_cnt = 8'd1;
    n_ack = 0;
    for (int c = 0; c < 300; c++) begin
      #1 if (ack_pkt2user == 2'b01) n_ack++;
      tick();
    end
    vld_user2pkt = 2'b00; credit_vld = 1'b0;
    tick();
    chk("stream_count", 64'(n_ack), 64'd300);
`ifdef LEAF_PKT_STATS_EN
    chk("stat_port0", 64'(stat_sent[15:0]), 64'd300);
`else
    chk("stat_port0", 64'(stat_sent[15:0]), 64'd0);
`endif
    chk("stat_port1", 64'(stat_sent[31:16]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
